pifo_tree_client: RTL
=====================

PIFO_TREE_CLIENT -- requirements
Module: pifo_tree_client

Interface
REQ-001 SHALL have parameter PTW, default 16, payload width.
REQ-002 SHALL have parameter MTW, default 0, metadata width; the data word is DW = MTW+PTW.
REQ-003 SHALL have parameter TREE_NUM, default 4, number of trees; TIDW = $clog2(TREE_NUM).
REQ-004 SHALL have parameter POP_LAT, default 4, cycles from o_pop to a valid i_pop_data.
REQ-005 SHALL have parameter CTW, default 10, statistics counter width.
REQ-006 SHALL have ports: i_clk in 1 (single clock); i_rst in 1 (synchronous, active-high reset).
REQ-007 SHALL have command ports: i_cmd_valid in 1; o_cmd_ready out 1; i_cmd_op in 1 (0 = push, 1 = pop); i_cmd_tree_id in TIDW; i_cmd_data in DW.
REQ-008 SHALL have tree-port ports: o_push out 1; o_pop out 1; o_tree_id out TIDW; o_push_data out DW; i_task_fifo_full in 1; i_pop_data in DW.
REQ-009 SHALL have response ports: o_rsp_valid out 1; o_rsp_data out DW; o_rsp_tree_id out TIDW; o_rsp_empty out 1.
REQ-010 SHALL have control ports: i_drain in 1; o_drained out 1; o_push_cnt out CTW; o_pop_cnt out CTW; o_empty_cnt out CTW.

Function
REQ-011 SHALL accept a command when i_cmd_valid && o_cmd_ready, into a 2-entry skid buffer.
REQ-012 SHALL assert o_cmd_ready when the buffer has a free entry and the state is RUN.
REQ-013 SHALL issue the oldest buffered command when the buffer is non-empty, the state is RUN or DRAIN, and i_task_fifo_full = 0 in that cycle.
REQ-014 SHALL register the issue outputs: o_push or o_pop is high for exactly one cycle per command, and the two are never high together.
REQ-015 SHALL drive o_push_data equal to the command data on a push, and all-zero otherwise.
REQ-016 SHALL keep o_tree_id equal to the issued command's tree id during the issue cycle.
REQ-017 SHALL issue at most one command per cycle; throughput is 1 per cycle while not full.
REQ-018 SHALL, when full asserts, hold the pending command unchanged and issue nothing until full deasserts.
REQ-019 SHALL, for each pop issued in cycle t, assert o_rsp_valid in cycle t+POP_LAT+1.
REQ-020 SHALL drive o_rsp_data = i_pop_data sampled at cycle t+POP_LAT.
REQ-021 SHALL drive o_rsp_tree_id equal to the tree id of that pop.
REQ-022 SHALL return pop responses in issue order.
REQ-023 SHALL set o_rsp_empty = 1 when o_rsp_data is all-ones, because all-ones marks an empty tree.
REQ-024 SHALL keep an outstanding-pop count of width $clog2(POP_LAT+2); it increments on issue and decrements on response, and both in one cycle leave it unchanged.
REQ-025 SHALL implement states IDLE, RUN and DRAIN.
REQ-026 SHALL go IDLE->RUN one cycle after reset release.
REQ-027 SHALL go RUN->DRAIN when i_drain = 1.
REQ-028 SHALL go DRAIN->IDLE when the buffer is empty and no pops are outstanding.
REQ-029 SHALL go IDLE->RUN when i_drain = 0.
REQ-030 SHALL assert o_drained only in IDLE.
REQ-031 SHALL, in DRAIN, keep o_cmd_ready = 0 and keep issuing buffered commands.
REQ-032 SHALL, when i_cmd_valid and a response occur in the same cycle, handle both independently.

Reset
REQ-033 SHALL, on i_rst = 1 at a clock edge, clear the buffer, the pop pipeline, the outstanding count and the counters, and enter IDLE.
REQ-034 SHALL hold all outputs at 0 during and after reset until the first issue: o_push, o_pop, o_tree_id, o_push_data, o_rsp_*, o_cmd_ready, counters.
REQ-035 SHALL hold o_drained = 1 during reset.
REQ-036 SHALL, on reset mid-operation, discard in-flight pops and never emit their responses.

Configuration
REQ-037 SHALL, with PIFO_CLIENT_STATS_EN defined, count issued pushes (o_push_cnt), issued pops (o_pop_cnt) and empty responses (o_empty_cnt); each counter saturates at 2^CTW-1.
REQ-038 SHALL, without PIFO_CLIENT_STATS_EN, tie the three counters to 0 and infer no counter flops.

Structure
REQ-039 SHALL place the op encoding (PUSH, POP) and the state enum (IDLE, RUN, DRAIN) in the shared package pifo_client_pkg.
REQ-040 SHALL implement the pop delay line (valid plus tree id, depth POP_LAT) in the sub-module pifo_pop_tracker.

Verification
REQ-041 Bench SHALL cover: reset, then push tree 2 data 0x0005 -> o_push = 1 exactly one cycle, o_tree_id = 2, o_push_data = 0x0005.
REQ-042 Bench SHALL cover: pop tree 1 with i_pop_data = 0x0005 at t+4 -> o_rsp_valid at t+5, o_rsp_data = 0x0005, o_rsp_tree_id = 1, o_rsp_empty = 0.
REQ-043 Bench SHALL cover: pop while i_pop_data = 0xFFFF -> o_rsp_empty = 1; o_empty_cnt = 1 when STATS_EN is defined.
REQ-044 Bench SHALL cover: full held high 3 cycles with 2 commands buffered -> no issue, o_cmd_ready = 0; both issue in order on the 2 cycles after full drops.
REQ-045 Bench SHALL cover: i_drain with 2 pops outstanding -> o_drained rises the cycle after the last response.
REQ-046 Bench SHALL cover: i_rst asserted 1 cycle after a pop issue -> no o_rsp_valid in the following 10 cycles.

Source files
------------

// File: rtl/pifo_client_pkg.sv
// Shared encodings for the PIFO tree client: command opcodes and controller states.
package pifo_client_pkg;

  localparam logic OpPush = 1'b0;
  localparam logic OpPop  = 1'b1;

  typedef logic [1:0] client_state_t;

  localparam client_state_t StIdle  = 2'd0;
  localparam client_state_t StRun   = 2'd1;
  localparam client_state_t StDrain = 2'd2;

endpackage

// File: rtl/pifo_pop_tracker.sv
// Delay line that follows each issued pop (valid + tree id) for POP_LAT cycles,
// so the tap lines up with the cycle in which the tree presents its pop data.
module pifo_pop_tracker
  import pifo_client_pkg::*;
#(
  parameter int unsigned POP_LAT = 4,
  parameter int unsigned TIDW    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_pop,
  input  logic [TIDW-1:0] i_tree_id,
  output logic            o_valid,
  output logic [TIDW-1:0] o_tree_id
);

  logic [POP_LAT-1:0]           vld_q, vld_d;
  logic [POP_LAT-1:0][TIDW-1:0] tid_q, tid_d;

  always_comb begin
    vld_d    = '0;
    tid_d    = '0;
    vld_d[0] = i_pop;
    tid_d[0] = i_pop ? i_tree_id : '0;
    for (int unsigned i = 1; i < POP_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tid_d[i] = tid_q[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
      tid_q <= '0;
    end else begin
      vld_q <= vld_d;
      tid_q <= tid_d;
    end
  end

  assign o_valid   = vld_q[POP_LAT-1];
  assign o_tree_id = tid_q[POP_LAT-1];

endmodule

// File: rtl/pifo_tree_client.sv
// PIFO tree client: buffers push/pop commands, issues them to the tree port and
// returns pop responses in order. Optional statistics counters: PIFO_CLIENT_STATS_EN.
module pifo_tree_client
  import pifo_client_pkg::*;
#(
  parameter int unsigned PTW      = 16,
  parameter int unsigned MTW      = 0,
  parameter int unsigned TREE_NUM = 4,
  parameter int unsigned POP_LAT  = 4,
  parameter int unsigned CTW      = 10,
  localparam int unsigned DW      = MTW + PTW,
  localparam int unsigned TIDW    = $clog2(TREE_NUM)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  // Command side
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_op,
  input  logic [TIDW-1:0] i_cmd_tree_id,
  input  logic [DW-1:0]   i_cmd_data,
  // Tree port
  output logic            o_push,
  output logic            o_pop,
  output logic [TIDW-1:0] o_tree_id,
  output logic [DW-1:0]   o_push_data,
  input  logic            i_task_fifo_full,
  input  logic [DW-1:0]   i_pop_data,
  // Responses
  output logic            o_rsp_valid,
  output logic [DW-1:0]   o_rsp_data,
  output logic [TIDW-1:0] o_rsp_tree_id,
  output logic            o_rsp_empty,
  // Control and statistics
  input  logic            i_drain,
  output logic            o_drained,
  output logic [CTW-1:0]  o_push_cnt,
  output logic [CTW-1:0]  o_pop_cnt,
  output logic [CTW-1:0]  o_empty_cnt
);

  localparam int unsigned OW = $clog2(POP_LAT + 2);
  localparam logic [OW-1:0] OutOne = OW'(1);

  client_state_t state_q, state_d;

  // Two-entry command buffer; entry 0 is the oldest.
  logic [1:0]           cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [1:0][TIDW-1:0] tid_q, tid_d;
  logic [1:0][DW-1:0]   data_q, data_d;

  logic            push_q, push_d;
  logic            pop_q, pop_d;
  logic [TIDW-1:0] tree_id_q, tree_id_d;
  logic [DW-1:0]   push_data_q, push_data_d;

  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [TIDW-1:0] rsp_tid_q, rsp_tid_d;
  logic            rsp_empty_q, rsp_empty_d;

  logic [OW-1:0]   outst_q, outst_d;

  logic            trk_valid;
  logic [TIDW-1:0] trk_tid;

  logic accept, issue, active;
  logic wr_idx;

  assign active      = (state_q == StRun) || (state_q == StDrain);
  assign o_cmd_ready = (cnt_q != 2'd2) && (state_q == StRun) && !i_rst;
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign issue       = (cnt_q != 2'd0) && active && !i_task_fifo_full;

  always_comb begin
    op_d   = op_q;
    tid_d  = tid_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    wr_idx = 1'b0;
    if (issue) begin
      op_d[0]   = op_q[1];
      tid_d[0]  = tid_q[1];
      data_d[0] = data_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    if (accept) begin
      // After a same-cycle issue the free slot is the one just vacated.
      wr_idx         = cnt_d[0];
      op_d[wr_idx]   = i_cmd_op;
      tid_d[wr_idx]  = i_cmd_tree_id;
      data_d[wr_idx] = i_cmd_data;
      cnt_d          = cnt_d + 2'd1;
    end
  end

  always_comb begin
    push_d      = issue && (op_q[0] == OpPush);
    pop_d       = issue && (op_q[0] == OpPop);
    tree_id_d   = issue ? tid_q[0] : '0;
    push_data_d = push_d ? data_q[0] : '0;
  end

  pifo_pop_tracker #(
    .POP_LAT (POP_LAT),
    .TIDW    (TIDW)
  ) u_pop_tracker (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_pop     (pop_q),
    .i_tree_id (tree_id_q),
    .o_valid   (trk_valid),
    .o_tree_id (trk_tid)
  );

  always_comb begin
    rsp_valid_d = trk_valid;
    rsp_data_d  = trk_valid ? i_pop_data : '0;
    rsp_tid_d   = trk_valid ? trk_tid : '0;
    rsp_empty_d = trk_valid && (&i_pop_data);
  end

  always_comb begin
    outst_d = outst_q;
    case ({pop_q, rsp_valid_q})
      2'b10:   outst_d = outst_q + OutOne;
      2'b01:   outst_d = outst_q - OutOne;
      default: outst_d = outst_q;
    endcase
  end

  // Leaving DRAIN looks at next-cycle outstanding so o_drained rises right after the last response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (!i_drain) state_d = StRun;
      StRun:   if (i_drain) state_d = StDrain;
      StDrain: if ((cnt_q == 2'd0) && (outst_d == '0)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      tid_q       <= '0;
      data_q      <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      tree_id_q   <= '0;
      push_data_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tid_q   <= '0;
      rsp_empty_q <= 1'b0;
      outst_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      tid_q       <= tid_d;
      data_q      <= data_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      tree_id_q   <= tree_id_d;
      push_data_q <= push_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_empty_q <= rsp_empty_d;
      outst_q     <= outst_d;
    end
  end

  assign o_push        = push_q;
  assign o_pop         = pop_q;
  assign o_tree_id     = tree_id_q;
  assign o_push_data   = push_data_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_tree_id = rsp_tid_q;
  assign o_rsp_empty   = rsp_empty_q;
  assign o_drained     = (state_q == StIdle) || i_rst;

`ifdef PIFO_CLIENT_STATS_EN
  localparam logic [CTW-1:0] CntOne = CTW'(1);

  logic [CTW-1:0] push_cnt_q, push_cnt_d;
  logic [CTW-1:0] pop_cnt_q, pop_cnt_d;
  logic [CTW-1:0] empty_cnt_q, empty_cnt_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    push_cnt_d  = push_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    empty_cnt_d = empty_cnt_q;
    if (push_q && (push_cnt_q != '1))       push_cnt_d  = push_cnt_q + CntOne;
    if (pop_q && (pop_cnt_q != '1))         pop_cnt_d   = pop_cnt_q + CntOne;
    if (rsp_empty_q && (empty_cnt_q != '1)) empty_cnt_d = empty_cnt_q + CntOne;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      push_cnt_q  <= '0;
      pop_cnt_q   <= '0;
      empty_cnt_q <= '0;
    end else begin
      push_cnt_q  <= push_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      empty_cnt_q <= empty_cnt_d;
    end
  end

  assign o_push_cnt  = push_cnt_q;
  assign o_pop_cnt   = pop_cnt_q;
  assign o_empty_cnt = empty_cnt_q;
`else
  assign o_push_cnt  = '0;
  assign o_pop_cnt   = '0;
  assign o_empty_cnt = '0;
`endif

endmodule
